pipeline_stall_ctrl: RTL



---
 rtl/pipeline_stall_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline control for the 5-stage core: stage enables, bubbles and flushes,
// debug halt/drain/resume handshake, memory-wait timeout and saturating perf counters.
module pipeline_stall_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_write_en,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);
    localparam logic [WaitW-1:0]  WaitMax   = WaitW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e            state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  memw_q, memw_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              mem_stall;
    logic              inc_stall, inc_memw, inc_flush;

    assign mem_stall = dmem_req & ~dmem_ready;

    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_bubble    = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_bubble   = 1'b0;
        halted          = 1'b0;
        inc_stall       = 1'b0;
        inc_memw        = 1'b0;
        inc_flush       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    pc_write_en     = 1'b0;
                    if_id_write_en  = 1'b0;
                    id_ex_write_en  = 1'b0;
                    ex_mem_write_en = 1'b0;
                    mem_wb_bubble   = 1'b1;
                    inc_memw        = 1'b1;
                end else if (halt_req) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    state_d        = StDrain;
                    drain_d        = '0;
                end else if (hazard) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    inc_stall      = 1'b1;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    inc_flush   = 1'b1;
                end
            end
            StDrain: begin
                if (mem_stall) begin
                    pc_write_en     = 1'b0;
                    if_id_write_en  = 1'b0;
                    id_ex_write_en  = 1'b0;
                    ex_mem_write_en = 1'b0;
                    mem_wb_bubble   = 1'b1;
                    inc_memw        = 1'b1;
                end else begin
                    // Fetch stays frozen; hazard/branch wait until resume re-evaluates them.
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    if (drain_q == DrainLast) begin
                        state_d = StHalted;
                    end else begin
                        drain_d = drain_q + DrainW'(1);
                    end
                end
            end
            StHalted: begin
                halted         = 1'b1;
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_bubble   = 1'b1;
                mem_wb_bubble  = 1'b1;
                if (!halt_req) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (!arst_n) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_write_en  = 1'b0;
            id_ex_bubble    = 1'b1;
            ex_mem_write_en = 1'b0;
            mem_wb_bubble   = 1'b1;
            halted          = 1'b0;
        end
    end

    always_comb begin
        wait_d    = mem_stall ? ((wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1)) : '0;
        timeout_d = timeout_q | (wait_d == WaitMax);

        // Clear wins over increment; all counters stick at all-ones.
        if (cnt_clr) begin
            stall_d = '0;
            memw_d  = '0;
            flush_d = '0;
        end else begin
            stall_d = (inc_stall && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
            memw_d  = (inc_memw && memw_q != '1) ? memw_q + CNT_W'(1) : memw_q;
            flush_d = (inc_flush && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StRun;
            drain_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            memw_q    <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            memw_q    <= memw_d;
            flush_q   <= flush_d;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cnt    = stall_q;
    assign mem_wait_cnt = memw_q;
    assign flush_cnt    = flush_q;

endmodule
